// File: rtl/stream_mux_rr.sv
// stream_mux_rr
//   N-channel, W-bit streaming multiplexer with a valid/ready handshake
//   and one registered output stage. The channel is chosen by an external
//   select (MODE 0), round-robin (MODE 1) or fixed lowest-index priority
//   (MODE 2). Once a multi-beat packet starts, the grant stays on that
//   channel until its last beat is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sl         channel select, used only in MODE 0
//   in_valid   per-channel beat valid
//   in_ready   per-channel beat accepted this cycle (combinational, one-hot or zero)
//   in_data    channel i occupies bits [i*W +: W]
//   in_last    per-channel end-of-packet flag
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
//   out_data   registered data
//   out_last   registered last flag
//   out_chan   source channel index of the current beat
module stream_mux_rr #(
    parameter int W    = 32,
    parameter int N    = 4,
    parameter int SLW  = 2,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [SLW-1:0] sl,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic [SLW-1:0] out_chan
);

    logic           load_en;
    logic           grant_vld;
    logic [SLW-1:0] grant_chan;
    logic [W-1:0]   grant_data;
    logic           grant_last;
    logic           accept;

    logic           vld_p1;
    logic [W-1:0]   data_p1;
    logic           last_p1;
    logic [SLW-1:0] chan_p1;

    logic           locked;
    logic [SLW-1:0] lock_chan;
    logic [SLW-1:0] rr_ptr;

    // ---- Stage 0: grant selection on the incoming beats ----

    assign load_en = !vld_p1 | out_ready;

    always_comb begin : grant_sel
        int j;
        j          = 0;
        grant_vld  = 1'b0;
        grant_chan = '0;
        if (locked) begin
            // An open packet keeps its channel even if that channel stalls.
            for (int i = 0; i < N; i++) begin
                if (lock_chan == SLW'(i) && in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_chan = SLW'(i);
                end
            end
        end else if (MODE == 0) begin
            // Select values >= N never match a channel, so they grant nothing.
            for (int i = 0; i < N; i++) begin
                if (sl == SLW'(i) && in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_chan = SLW'(i);
                end
            end
        end else if (MODE == 1) begin
            // Scan offsets from far to near so the nearest valid channel at
            // or after rr_ptr is the last one written; wrap without needing
            // N to be a power of two.
            for (int k = N - 1; k >= 0; k--) begin
                j = int'(rr_ptr) + k;
                if (j >= N) j = j - N;
                if (in_valid[j]) begin
                    grant_vld  = 1'b1;
                    grant_chan = SLW'(j);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (in_valid[i]) begin
                    grant_vld  = 1'b1;
                    grant_chan = SLW'(i);
                end
            end
        end
    end

    always_comb begin : grant_mux
        grant_data = '0;
        grant_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant_chan == SLW'(i)) begin
                grant_data = in_data[i*W +: W];
                grant_last = in_last[i];
            end
        end
    end

    // rst_n gating keeps in_ready quiet while reset is held.
    assign accept = rst_n & load_en & grant_vld;

    always_comb begin : ready_gen
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = accept && (grant_chan == SLW'(i));
        end
    end

    // ---- Stage 1: output register, packet lock and round-robin pointer ----

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            data_p1   <= '0;
            last_p1   <= 1'b0;
            chan_p1   <= '0;
            locked    <= 1'b0;
            lock_chan <= '0;
            rr_ptr    <= '0;
        end else begin
            if (load_en) begin
                vld_p1 <= accept;
                if (accept) begin
                    data_p1 <= grant_data;
                    last_p1 <= grant_last;
                    chan_p1 <= grant_chan;
                end
            end
            if (accept) begin
                if (grant_last) begin
                    locked <= 1'b0;
                    rr_ptr <= (grant_chan == SLW'(N - 1)) ? '0 : grant_chan + 1'b1;
                end else begin
                    locked    <= 1'b1;
                    lock_chan <= grant_chan;
                end
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign out_chan  = chan_p1;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
        logic [1:0]  c;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   sl;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_last;
    logic         out_ready;

    // Output views: 0=rr4, 1=pr4, 2=ex4, 3=ex3, 4=rr3
    logic         ov [5];
    logic [31:0]  od [5];
    logic         ol [5];
    logic [1:0]   oc [5];
    logic [3:0]   ir_rr4, ir_pr4, ir_ex4;
    logic [2:0]   ir_ex3, ir_rr3;

    beat_t sb[$];
    beat_t exp_b;
    beat_t got_b;
    int    tests = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    stream_mux_rr #(.W(32), .N(4), .SLW(2), .MODE(1)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .sl(sl), .in_valid(in_valid), .in_ready(ir_rr4),
        .in_data(in_data), .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_last(ol[0]), .out_chan(oc[0]));

    stream_mux_rr #(.W(32), .N(4), .SLW(2), .MODE(2)) u_pr4 (
        .clk(clk), .rst_n(rst_n), .sl(sl), .in_valid(in_valid), .in_ready(ir_pr4),
        .in_data(in_data), .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_last(ol[1]), .out_chan(oc[1]));

    stream_mux_rr #(.W(32), .N(4), .SLW(2), .MODE(0)) u_ex4 (
        .clk(clk), .rst_n(rst_n), .sl(sl), .in_valid(in_valid), .in_ready(ir_ex4),
        .in_data(in_data), .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_last(ol[2]), .out_chan(oc[2]));

    stream_mux_rr #(.W(32), .N(3), .SLW(2), .MODE(0)) u_ex3 (
        .clk(clk), .rst_n(rst_n), .sl(sl), .in_valid(in_valid[2:0]), .in_ready(ir_ex3),
        .in_data(in_data[95:0]), .in_last(in_last[2:0]), .out_valid(ov[3]), .out_ready(out_ready),
        .out_data(od[3]), .out_last(ol[3]), .out_chan(oc[3]));

    stream_mux_rr #(.W(32), .N(3), .SLW(2), .MODE(1)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .sl(sl), .in_valid(in_valid[2:0]), .in_ready(ir_rr3),
        .in_data(in_data[95:0]), .in_last(in_last[2:0]), .out_valid(ov[4]), .out_ready(out_ready),
        .out_data(od[4]), .out_last(ol[4]), .out_chan(oc[4]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [31:0] d, input logic l);
        in_data[i*32 +: 32] = d;
        in_last[i]          = l;
    endtask

    task automatic push(input logic [31:0] d, input logic l, input logic [1:0] c);
        beat_t b;
        b.d = d;
        b.l = l;
        b.c = c;
        sb.push_back(b);
    endtask

    task automatic do_reset;
        in_valid  = '0;
        in_last   = '0;
        in_data   = '0;
        sl        = '0;
        out_ready = 1'b1;
        sb.delete();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h100 + i, 1'b1);
        tick();
        tick();
        tests++;
        if (ir_rr4 !== 4'b0000 || ov[0] !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle in_ready=%b out_valid=%b want 0000/0", ir_rr4, ov[0]);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests++;
            if (ir_rr4 !== 4'(1 << (k % 4))) begin
                fails++;
                $display("FAIL rr_ready%0d got %b want %b", k, ir_rr4, 4'(1 << (k % 4)));
            end
            push(32'h100 + (k % 4), 1'b1, 2'(k % 4));
            tick();
            if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
            got_b = {od[0], ol[0], oc[0]};
            tests++;
            if (ov[0] !== 1'b1 || got_b !== exp_b) begin
                fails++;
                $display("FAIL rr_beat%0d got v=%b %h want %h", k, ov[0], got_b, exp_b);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        in_valid = 4'b0100;
        set_ch(2, 32'hA5A5A5A5, 1'b1);
        #1;
        tests++;
        if (ir_rr4 !== 4'b0100) begin
            fails++;
            $display("FAIL bp_first_ready got %b want 0100", ir_rr4);
        end
        push(32'hA5A5A5A5, 1'b1, 2'd2);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[0], ol[0], oc[0]};
        tests++;
        if (ov[0] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL bp_beat got v=%b %h want %h", ov[0], got_b, exp_b);
        end
        out_ready = 1'b0;
        set_ch(2, 32'h5A5A5A5A, 1'b1);
        for (int k = 0; k < 3; k++) begin
            #1;
            tests++;
            if (ir_rr4 !== 4'b0000) begin
                fails++;
                $display("FAIL bp_stall_ready%0d got %b want 0000", k, ir_rr4);
            end
            tick();
            tests++;
            if (ov[0] !== 1'b1 || od[0] !== 32'hA5A5A5A5 || oc[0] !== 2'd2) begin
                fails++;
                $display("FAIL bp_hold%0d got v=%b d=%h c=%0d want 1/a5a5a5a5/2", k, ov[0], od[0], oc[0]);
            end
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (ir_rr4 !== 4'b0100) begin
            fails++;
            $display("FAIL bp_release_ready got %b want 0100", ir_rr4);
        end
        push(32'h5A5A5A5A, 1'b1, 2'd2);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[0], ol[0], oc[0]};
        tests++;
        if (ov[0] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL bp_next_beat got v=%b %h want %h", ov[0], got_b, exp_b);
        end
    endtask

    task automatic test_packet_lock;
        logic [3:0]  vpat [5];
        logic [3:0]  rpat [5];
        logic [31:0] d1   [5];
        logic        l1   [5];
        vpat = '{4'b0010, 4'b0011, 4'b0001, 4'b0011, 4'b0001};
        rpat = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0001};
        d1   = '{32'h11, 32'h12, 32'h0, 32'h13, 32'h0};
        l1   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        set_ch(0, 32'h01, 1'b1);
        for (int k = 0; k < 5; k++) begin
            in_valid = vpat[k];
            set_ch(1, d1[k], l1[k]);
            #1;
            tests++;
            if (ir_pr4 !== rpat[k]) begin
                fails++;
                $display("FAIL lock_ready%0d got %b want %b", k, ir_pr4, rpat[k]);
            end
            if (rpat[k] == 4'b0010) push(d1[k], l1[k], 2'd1);
            else if (rpat[k] == 4'b0001) push(32'h01, 1'b1, 2'd0);
            tick();
            if (rpat[k] == 4'b0000) begin
                tests++;
                if (ov[1] !== 1'b0) begin
                    fails++;
                    $display("FAIL lock_gap_valid got %b want 0", ov[1]);
                end
            end else begin
                if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
                got_b = {od[1], ol[1], oc[1]};
                tests++;
                if (ov[1] !== 1'b1 || got_b !== exp_b) begin
                    fails++;
                    $display("FAIL lock_beat%0d got v=%b %h want %h", k, ov[1], got_b, exp_b);
                end
            end
        end
    endtask

    task automatic test_ext_select;
        do_reset();
        sl       = 2'd3;
        in_valid = 4'b1000;
        set_ch(3, 32'h33, 1'b1);
        #1;
        tests++;
        if (ir_ex4 !== 4'b1000 || ir_ex3 !== 3'b000) begin
            fails++;
            $display("FAIL sel3_ready got %b/%b want 1000/000", ir_ex4, ir_ex3);
        end
        push(32'h33, 1'b1, 2'd3);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[2], ol[2], oc[2]};
        tests++;
        if (ov[2] !== 1'b1 || got_b !== exp_b || ov[3] !== 1'b0) begin
            fails++;
            $display("FAIL sel3_beat got v=%b %h n3v=%b want 1 %h 0", ov[2], got_b, ov[3], exp_b);
        end
        in_valid = 4'b0001;
        set_ch(0, 32'h44, 1'b1);
        #1;
        tests++;
        if (ir_ex4 !== 4'b0000 || ir_ex3 !== 3'b000) begin
            fails++;
            $display("FAIL sel3_nogrant_ready got %b/%b want 0000/000", ir_ex4, ir_ex3);
        end
        tick();
        tests++;
        if (ov[2] !== 1'b0 || ov[3] !== 1'b0) begin
            fails++;
            $display("FAIL sel3_valid_fall got %b/%b want 0/0", ov[2], ov[3]);
        end
        sl       = 2'd2;
        in_valid = 4'b0100;
        set_ch(2, 32'h22, 1'b1);
        #1;
        tests++;
        if (ir_ex3 !== 3'b100) begin
            fails++;
            $display("FAIL n3_sel2_ready got %b want 100", ir_ex3);
        end
        push(32'h22, 1'b1, 2'd2);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[3], ol[3], oc[3]};
        tests++;
        if (ov[3] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL n3_sel2_beat got v=%b %h want %h", ov[3], got_b, exp_b);
        end
    endtask

    task automatic test_rr_wrap;
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'h200 + i, 1'b1);
        in_valid = 4'b0100;
        #1;
        push(32'h202, 1'b1, 2'd2);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[4], ol[4], oc[4]};
        tests++;
        if (ov[4] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL wrap_ch2 got v=%b %h want %h", ov[4], got_b, exp_b);
        end
        in_valid = 4'b0111;
        #1;
        tests++;
        if (ir_rr3 !== 3'b001) begin
            fails++;
            $display("FAIL wrap_ready got %b want 001", ir_rr3);
        end
        push(32'h200, 1'b1, 2'd0);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[4], ol[4], oc[4]};
        tests++;
        if (ov[4] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL wrap_ch0 got v=%b %h want %h", ov[4], got_b, exp_b);
        end
    endtask

    task automatic test_reset_mid_packet;
        do_reset();
        in_valid = 4'b0010;
        set_ch(1, 32'h11, 1'b0);
        set_ch(0, 32'h01, 1'b1);
        tick();
        in_valid = 4'b0011;
        set_ch(1, 32'h12, 1'b0);
        #1;
        tests++;
        if (ir_pr4 !== 4'b0010 || ov[1] !== 1'b1 || oc[1] !== 2'd1) begin
            fails++;
            $display("FAIL midrst_locked got r=%b v=%b c=%0d want 0010/1/1", ir_pr4, ov[1], oc[1]);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (ov[1] !== 1'b0 || ir_pr4 !== 4'b0000) begin
            fails++;
            $display("FAIL midrst_flush got v=%b r=%b want 0/0000", ov[1], ir_pr4);
        end
        rst_n = 1'b1;
        #1;
        tests++;
        if (ir_pr4 !== 4'b0001) begin
            fails++;
            $display("FAIL midrst_unlock_ready got %b want 0001", ir_pr4);
        end
        push(32'h01, 1'b1, 2'd0);
        tick();
        if (sb.size() != 0) exp_b = sb.pop_front(); else exp_b = '1;
        got_b = {od[1], ol[1], oc[1]};
        tests++;
        if (ov[1] !== 1'b1 || got_b !== exp_b) begin
            fails++;
            $display("FAIL midrst_ch0 got v=%b %h want %h", ov[1], got_b, exp_b);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sl        = '0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;
        test_reset();
        test_backpressure();
        test_packet_lock();
        test_ext_select();
        test_rr_wrap();
        test_reset_mid_packet();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
